// File: rtl/reset_release_sequencer.sv
// Releases per-subsystem resets one stage at a time once the upstream timer permits it.
// Each stage must report init-done within TIMEOUT ungated cycles before the next stage is released.
module reset_release_sequencer #(
  parameter int NUM_STAGES = 4,
  parameter int TIMEOUT    = 16,
  parameter int GAP        = 2,
  localparam int SW        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  release_reset_i,
  input  logic                  gate_clk_i,
  input  logic [NUM_STAGES-1:0] done_i,
  output logic [NUM_STAGES-1:0] subsys_rst_o,
  output logic                  clk_en_o,
  output logic                  seq_done_o,
  output logic                  timeout_err_o,
  output logic [SW-1:0]         err_stage_o
);

  localparam int TMAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int TW   = $clog2(TMAX) + 1;

  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP - 1);
  localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DONE,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_e;

  state_e                  state_q, state_d;
  logic [SW-1:0]           stage_q, stage_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [NUM_STAGES-1:0]   subsys_rst_q, subsys_rst_d;
  logic                    clk_en_q, clk_en_d;
  logic                    seq_done_q, seq_done_d;
  logic                    timeout_err_q, timeout_err_d;
  logic [SW-1:0]           err_stage_q, err_stage_d;
  logic [SW-1:0]           stage_inc;

  assign stage_inc = stage_q + SW'(1);

  always_comb begin
    state_d       = state_q;
    stage_d       = stage_q;
    timer_d       = timer_q;
    subsys_rst_d  = subsys_rst_q;
    seq_done_d    = seq_done_q;
    timeout_err_d = timeout_err_q;
    err_stage_d   = err_stage_q;
    clk_en_d      = release_reset_i & ~gate_clk_i;

    // Losing release permission outside IDLE unwinds the whole sequence, including a latched error.
    if ((state_q != S_IDLE) && !release_reset_i) begin
      state_d       = S_IDLE;
      stage_d       = '0;
      timer_d       = '0;
      subsys_rst_d  = '1;
      seq_done_d    = 1'b0;
      timeout_err_d = 1'b0;
      err_stage_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (release_reset_i && !gate_clk_i) begin
            state_d         = S_WAIT_DONE;
            stage_d         = '0;
            timer_d         = '0;
            subsys_rst_d    = '1;
            subsys_rst_d[0] = 1'b0;
          end
        end

        S_WAIT_DONE: begin
          if (!gate_clk_i) begin
            if (done_i[stage_q]) begin
              if (stage_q == LAST_STAGE) begin
                state_d      = S_DONE;
                subsys_rst_d = '0;
                seq_done_d   = 1'b1;
              end else begin
                state_d = S_GAP;
                timer_d = '0;
              end
            end else if (timer_q == TMO_LAST) begin
              state_d       = S_ERROR;
              subsys_rst_d  = '1;
              timeout_err_d = 1'b1;
              err_stage_d   = stage_q;
            end else begin
              timer_d = timer_q + TW'(1);
            end
          end
        end

        S_GAP: begin
          if (!gate_clk_i) begin
            if (timer_q == GAP_LAST) begin
              state_d                 = S_WAIT_DONE;
              stage_d                 = stage_inc;
              timer_d                 = '0;
              subsys_rst_d[stage_inc] = 1'b0;
            end else begin
              timer_d = timer_q + TW'(1);
            end
          end
        end

        S_DONE, S_ERROR: begin
        end

        default: begin
          state_d      = S_IDLE;
          stage_d      = '0;
          timer_d      = '0;
          subsys_rst_d = '1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      stage_q       <= '0;
      timer_q       <= '0;
      subsys_rst_q  <= '1;
      clk_en_q      <= 1'b0;
      seq_done_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      err_stage_q   <= '0;
    end else begin
      state_q       <= state_d;
      stage_q       <= stage_d;
      timer_q       <= timer_d;
      subsys_rst_q  <= subsys_rst_d;
      clk_en_q      <= clk_en_d;
      seq_done_q    <= seq_done_d;
      timeout_err_q <= timeout_err_d;
      err_stage_q   <= err_stage_d;
    end
  end

  assign subsys_rst_o  = subsys_rst_q;
  assign clk_en_o      = clk_en_q;
  assign seq_done_o    = seq_done_q;
  assign timeout_err_o = timeout_err_q;
  assign err_stage_o   = err_stage_q;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Bench for reset_release_sequencer: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a counting model of the release sequence.
module tb_reset_release_sequencer;

  localparam int NS      = 4;
  localparam int TIMEOUT = 16;
  localparam int GAP     = 2;

  logic          clk;
  logic          reset;
  logic          rr;
  logic          gc;
  logic [NS-1:0] done;
  logic [NS-1:0] subsys_rst;
  logic          clk_en;
  logic          seq_done;
  logic          tmo_err;
  logic [1:0]    err_stage;

  reset_release_sequencer #(
    .NUM_STAGES(NS),
    .TIMEOUT   (TIMEOUT),
    .GAP       (GAP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .release_reset_i(rr),
    .gate_clk_i     (gc),
    .done_i         (done),
    .subsys_rst_o   (subsys_rst),
    .clk_en_o       (clk_en),
    .seq_done_o     (seq_done),
    .timeout_err_o  (tmo_err),
    .err_stage_o    (err_stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Model: how many stages are released, how long the current one has waited, settle cycles left.
  bit m_valid    = 0;
  bit m_running  = 0;
  bit m_finished = 0;
  bit m_failed   = 0;
  int m_released = 0;
  int m_waited   = 0;
  int m_settle   = 0;
  bit m_clk_en   = 0;

  task automatic model_clear();
    m_running  = 0;
    m_finished = 0;
    m_failed   = 0;
    m_released = 0;
    m_waited   = 0;
    m_settle   = 0;
  endtask

  always @(posedge clk) begin
    m_clk_en = reset ? 1'b0 : (rr & ~gc);
    if (reset) begin
      model_clear();
    end else if (m_running && !rr) begin
      model_clear();
    end else if (!m_running) begin
      if (rr && !gc) begin
        m_running  = 1;
        m_released = 1;
        m_waited   = 0;
        m_settle   = 0;
      end
    end else if (!(m_finished || m_failed) && !gc) begin
      if (m_settle > 0) begin
        m_settle--;
        if (m_settle == 0) begin
          m_released++;
          m_waited = 0;
        end
      end else if (done[m_released-1]) begin
        if (m_released == NS) m_finished = 1;
        else m_settle = GAP;
      end else if (m_waited == TIMEOUT - 1) begin
        m_failed = 1;
      end else begin
        m_waited++;
      end
    end
    m_valid = 1;
  end

  function automatic logic [NS-1:0] exp_rst();
    int held;
    if (!m_running || m_failed) return '1;
    held = ((1 << NS) - 1) & ~((1 << m_released) - 1);
    return NS'(held);
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_rst", 32'(subsys_rst), 32'(exp_rst()));
      chk("model_clk_en", 32'(clk_en), 32'(m_clk_en));
      chk("model_seq_done", 32'(seq_done), 32'(m_finished));
      chk("model_tmo_err", 32'(tmo_err), 32'(m_failed));
      if (m_failed) chk("model_err_stage", 32'(err_stage), 32'(m_released - 1));
    end
  end

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rr    = 1'b0;
    gc    = 1'b0;
    done  = '0;
    tick();
    tick();
    chk("rst_state_rst", 32'(subsys_rst), 32'hF);
    chk("rst_state_clk_en", 32'(clk_en), 32'h0);
    chk("rst_state_seq_done", 32'(seq_done), 32'h0);
    chk("rst_state_tmo_err", 32'(tmo_err), 32'h0);
    chk("rst_state_err_stage", 32'(err_stage), 32'h0);
    reset = 1'b0;
    cyc   = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rel;
    int dprob;
    reset = 1'b1;
    rr    = 1'b0;
    gc    = 1'b0;
    done  = '0;

    // Normal sequence
    do_reset();
    rr = 1'b1;
    tick();
    chk("norm_rst_c1", 32'(subsys_rst), 32'hE);
    chk("norm_clken_c1", 32'(clk_en), 32'h1);
    while (cyc < 3) tick();
    done[0] = 1'b1;
    while (cyc < 6) tick();
    chk("norm_rst_c6", 32'(subsys_rst), 32'hC);
    rel = 6;
    for (int k = 1; k < NS; k++) begin
      while (cyc < rel + 2) tick();
      done[k] = 1'b1;
      if (k < NS - 1) begin
        while (cyc < rel + GAP + 3) tick();
        rel = rel + GAP + 3;
      end
    end
    chk("norm_rst_c16", 32'(subsys_rst), 32'h0);
    chk("norm_seqdone_c18", 32'(seq_done), 32'h0);
    tick();
    chk("norm_seqdone_c19", 32'(seq_done), 32'h1);
    chk("norm_rst_c19", 32'(subsys_rst), 32'h0);

    // Timeout at stage 0
    do_reset();
    rr = 1'b1;
    while (cyc < 16) tick();
    chk("tmo_noerr_c16", 32'(tmo_err), 32'h0);
    tick();
    chk("tmo_err_c17", 32'(tmo_err), 32'h1);
    chk("tmo_stage_c17", 32'(err_stage), 32'h0);
    chk("tmo_rst_c17", 32'(subsys_rst), 32'hF);
    rr = 1'b0;
    tick();
    chk("tmo_abort_err", 32'(tmo_err), 32'h0);
    chk("tmo_abort_rst", 32'(subsys_rst), 32'hF);

    // Gating freeze during stage 1 wait
    do_reset();
    rr = 1'b1;
    while (cyc < 3) tick();
    done = 4'b0001;
    while (cyc < 6) tick();
    done = 4'b0011;
    gc   = 1'b1;
    tick();
    chk("gate_clken_off", 32'(clk_en), 32'h0);
    while (cyc < 16) begin
      chk("gate_hold_rst", 32'(subsys_rst), 32'hC);
      tick();
    end
    chk("gate_hold_rst_c16", 32'(subsys_rst), 32'hC);
    gc = 1'b0;
    tick();
    tick();
    chk("gate_gap_rst_c18", 32'(subsys_rst), 32'hC);
    tick();
    chk("gate_ack_rst_c19", 32'(subsys_rst), 32'h8);

    // Abort mid-sequence and restart
    do_reset();
    rr = 1'b1;
    while (cyc < 3) tick();
    done = 4'b0001;
    while (cyc < 6) tick();
    chk("abort_pre_rst", 32'(subsys_rst), 32'hC);
    rr   = 1'b0;
    done = '0;
    tick();
    chk("abort_rst", 32'(subsys_rst), 32'hF);
    chk("abort_seqdone", 32'(seq_done), 32'h0);
    rr = 1'b1;
    tick();
    chk("abort_restart_rst", 32'(subsys_rst), 32'hE);

    // Start gated, then wrong-stage done only
    do_reset();
    rr = 1'b1;
    gc = 1'b1;
    repeat (4) begin
      tick();
      chk("startgate_rst", 32'(subsys_rst), 32'hF);
    end
    gc   = 1'b0;
    done = 4'b1110;
    rel  = cyc + 1;
    while (cyc < rel + TIMEOUT - 1) tick();
    chk("wrong_noerr", 32'(tmo_err), 32'h0);
    tick();
    chk("wrong_err", 32'(tmo_err), 32'h1);
    chk("wrong_err_stage", 32'(err_stage), 32'h0);

    // Reset asserted while in GAP with done high
    do_reset();
    rr = 1'b1;
    while (cyc < 3) tick();
    done = 4'b1111;
    tick();
    reset = 1'b1;
    tick();
    chk("gaprst_rst", 32'(subsys_rst), 32'hF);
    chk("gaprst_clken", 32'(clk_en), 32'h0);
    chk("gaprst_seqdone", 32'(seq_done), 32'h0);
    chk("gaprst_err", 32'(tmo_err), 32'h0);
    reset = 1'b0;
    rr    = 1'b0;
    done  = '0;
    tick();

    // Randomized traffic
    dprob = 2;
    for (int i = 0; i < 4000; i++) begin
      if (i % 150 == 0) dprob = $urandom_range(0, 3);
      reset = ($urandom_range(0, 299) == 0);
      rr    = ($urandom_range(0, 59) != 0);
      gc    = ($urandom_range(0, 9) < 2);
      for (int b = 0; b < NS; b++) done[b] = ($urandom_range(0, 9) < dprob * 3);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
